// File: rtl/instr_fetch_unit.sv
// Fetch stage: services sequencer fetch/operand states with one memory read each, owns PC/IR/OPR.
// Optional macro FETCH_TIMEOUT_EN adds a response timeout with a sticky fetch_err.
module instr_fetch_unit #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic [5:0]        state,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              advance,
  output logic [DATA_W-1:0] IR,
  output logic [DATA_W-1:0] OPR,
  output logic [ADDR_W-1:0] PC,
  output logic              fetch_err
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_REQ = 1'b1} fsm_e;

  localparam logic [5:0] ST_FETCH1 = 6'd1;
  localparam logic [5:0] ST_LDAC1  = 6'd5;
  localparam logic [5:0] ST_STAC1  = 6'd9;

  fsm_e              fsm_q, fsm_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] opr_q, opr_d;
  logic              req_q, req_d;
  logic              done_q, done_d;
  logic [5:0]        svc_state_q, svc_state_d;
  logic              svc_s;
  logic              done_eff_s;
  logic              err_s;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [3:0] TIMEOUT_CNT = 4'(TIMEOUT);
  logic [3:0] wait_q, wait_d;
  logic       err_q, err_d;
  assign err_s = err_q;
`else
  assign err_s = 1'b0;
`endif

  assign svc_s = (state == ST_FETCH1) | (state == ST_LDAC1) | (state == ST_STAC1);
  // done only counts while the sequencer is still in the state that was serviced
  assign done_eff_s = done_q & (state == svc_state_q);
  assign advance    = run & ~err_s & ~(svc_s & ~done_eff_s);

  assign mem_req   = req_q;
  assign mem_addr  = addr_q;
  assign IR        = ir_q;
  assign OPR       = opr_q;
  assign PC        = pc_q;
  assign fetch_err = err_s;

  // Next-state logic for the request FSM and the architectural registers
  always_comb begin
    fsm_d       = fsm_q;
    pc_d        = pc_q;
    addr_d      = addr_q;
    ir_d        = ir_q;
    opr_d       = opr_q;
    req_d       = req_q;
    done_d      = done_eff_s;
    svc_state_d = svc_state_q;
`ifdef FETCH_TIMEOUT_EN
    wait_d      = wait_q;
    err_d       = err_q;
`endif
    case (fsm_q)
      S_IDLE: begin
        if (svc_s & ~done_eff_s & run & ~err_s) begin
          fsm_d       = S_REQ;
          req_d       = 1'b1;
          addr_d      = pc_q;
          svc_state_d = state;
        end else begin
          fsm_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (mem_rvalid) begin
          // destination follows the latched state, not the live one
          case (svc_state_q)
            ST_FETCH1:          ir_d  = mem_rdata;
            ST_LDAC1, ST_STAC1: opr_d = mem_rdata;
            default:            ir_d  = ir_q;
          endcase
          pc_d   = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          req_d  = 1'b0;
          done_d = 1'b1;
          fsm_d  = S_IDLE;
`ifdef FETCH_TIMEOUT_EN
          wait_d = 4'd0;
`endif
        end else begin
`ifdef FETCH_TIMEOUT_EN
          if (wait_q == (TIMEOUT_CNT - 4'd1)) begin
            req_d  = 1'b0;
            err_d  = 1'b1;
            wait_d = 4'd0;
            fsm_d  = S_IDLE;
          end else begin
            wait_d = wait_q + 4'd1;
            fsm_d  = S_REQ;
          end
`else
          fsm_d = S_REQ;
`endif
        end
      end
      default: begin
        fsm_d = S_IDLE;
        req_d = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fsm_q       <= S_IDLE;
      pc_q        <= RESET_PC;
      addr_q      <= {ADDR_W{1'b0}};
      ir_q        <= {DATA_W{1'b0}};
      opr_q       <= {DATA_W{1'b0}};
      req_q       <= 1'b0;
      done_q      <= 1'b0;
      svc_state_q <= 6'd0;
`ifdef FETCH_TIMEOUT_EN
      wait_q      <= 4'd0;
      err_q       <= 1'b0;
`endif
    end else begin
      fsm_q       <= fsm_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      ir_q        <= ir_d;
      opr_q       <= opr_d;
      req_q       <= req_d;
      done_q      <= done_d;
      svc_state_q <= svc_state_d;
`ifdef FETCH_TIMEOUT_EN
      wait_q      <= wait_d;
      err_q       <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit; inputs driven 1ns after posedge, outputs checked at negedge.
module tb_instr_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        run;
  logic [5:0]  state;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        advance;
  logic [15:0] IR;
  logic [15:0] OPR;
  logic [7:0]  PC;
  logic        fetch_err;

  int errors = 0;
  int checks = 0;

  instr_fetch_unit dut (
    .clock(clock), .reset(reset), .run(run), .state(state),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .mem_req(mem_req), .mem_addr(mem_addr), .advance(advance),
    .IR(IR), .OPR(OPR), .PC(PC), .fetch_err(fetch_err)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Untimed fetch used to walk PC forward: request, 0-wait response, leave state.
  task automatic do_fetch(input logic [5:0] st, input logic [15:0] d);
    state = st; run = 1'b1; mem_rvalid = 1'b0;
    tick();
    mem_rvalid = 1'b1; mem_rdata = d;
    tick();
    mem_rvalid = 1'b0; state = 6'd0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b0; state = 6'd0; mem_rvalid = 1'b0; mem_rdata = 16'h0000;
    #12;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b exp 0", mem_req); end
    checks++; if (PC !== 8'h00) begin errors++; $display("FAIL rst_pc: got %h exp 00", PC); end
    checks++; if (IR !== 16'h0000 || OPR !== 16'h0000) begin errors++; $display("FAIL rst_ir_opr: got %h/%h exp 0000/0000", IR, OPR); end
    checks++; if (mem_addr !== 8'h00 || fetch_err !== 1'b0) begin errors++; $display("FAIL rst_addr_err: got %h/%b exp 00/0", mem_addr, fetch_err); end
    @(negedge clock);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_fetch_and_operand();
    // cycle 0: enter fetch1
    state = 6'd1; run = 1'b1; mem_rvalid = 1'b0;
    @(negedge clock);
    checks++; if (mem_req !== 1'b0 || advance !== 1'b0) begin errors++; $display("FAIL f_c0: got req=%b adv=%b exp 0/0", mem_req, advance); end
    tick();
    @(negedge clock);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 8'h00 || advance !== 1'b0) begin errors++; $display("FAIL f_c1: got req=%b addr=%h adv=%b exp 1/00/0", mem_req, mem_addr, advance); end
    tick();
    @(negedge clock);
    checks++; if (mem_req !== 1'b1 || advance !== 1'b0) begin errors++; $display("FAIL f_c2: got req=%b adv=%b exp 1/0", mem_req, advance); end
    tick();
    mem_rvalid = 1'b1; mem_rdata = 16'h0800;
    @(negedge clock);
    checks++; if (IR !== 16'h0000 || advance !== 1'b0) begin errors++; $display("FAIL f_c3: got IR=%h adv=%b exp 0000/0", IR, advance); end
    tick();
    mem_rvalid = 1'b0;
    @(negedge clock);
    checks++; if (IR !== 16'h0800 || PC !== 8'h01) begin errors++; $display("FAIL f_capture: got IR=%h PC=%h exp 0800/01", IR, PC); end
    checks++; if (mem_req !== 1'b0 || advance !== 1'b1) begin errors++; $display("FAIL f_adv: got req=%b adv=%b exp 0/1", mem_req, advance); end
    tick();
    // sequencer moves straight to ldac1, memory answers with zero wait states
    state = 6'd5;
    @(negedge clock);
    checks++; if (advance !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL o_c0: got adv=%b req=%b exp 0/0", advance, mem_req); end
    tick();
    mem_rvalid = 1'b1; mem_rdata = 16'h00A5;
    @(negedge clock);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 8'h01 || advance !== 1'b0) begin errors++; $display("FAIL o_c1: got req=%b addr=%h adv=%b exp 1/01/0", mem_req, mem_addr, advance); end
    tick();
    mem_rvalid = 1'b0;
    @(negedge clock);
    checks++; if (OPR !== 16'h00A5 || IR !== 16'h0800 || PC !== 8'h02) begin errors++; $display("FAIL o_capture: got OPR=%h IR=%h PC=%h exp 00A5/0800/02", OPR, IR, PC); end
    checks++; if (advance !== 1'b1) begin errors++; $display("FAIL o_adv: got %b exp 1", advance); end
    tick();
    state = 6'd0;
    tick();
  endtask

  task automatic test_non_service();
    logic [5:0] sts [3];
    sts[0] = 6'd2; sts[1] = 6'd4; sts[2] = 6'd15;
    run = 1'b1;
    for (int i = 0; i < 3; i++) begin
      state = sts[i]; mem_rvalid = 1'b1; mem_rdata = 16'hFFFF;
      @(negedge clock);
      checks++; if (advance !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL ns_%0d: got adv=%b req=%b exp 1/0", sts[i], advance, mem_req); end
      tick();
    end
    mem_rvalid = 1'b0;
    @(negedge clock);
    checks++; if (IR !== 16'h0800 || OPR !== 16'h00A5 || PC !== 8'h02) begin errors++; $display("FAIL ns_stray_rvalid: got IR=%h OPR=%h PC=%h exp 0800/00A5/02", IR, OPR, PC); end
    tick();
    run = 1'b0;
    @(negedge clock);
    checks++; if (advance !== 1'b0) begin errors++; $display("FAIL ns_run0: got %b exp 0", advance); end
    tick();
  endtask

  task automatic test_run_low_mid_request();
    state = 6'd9; run = 1'b1; mem_rvalid = 1'b0;
    tick();
    run = 1'b0; mem_rvalid = 1'b1; mem_rdata = 16'h3C3C;
    @(negedge clock);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 8'h02) begin errors++; $display("FAIL rl_req: got req=%b addr=%h exp 1/02", mem_req, mem_addr); end
    tick();
    mem_rvalid = 1'b0;
    @(negedge clock);
    checks++; if (OPR !== 16'h3C3C || PC !== 8'h03 || advance !== 1'b0) begin errors++; $display("FAIL rl_capture: got OPR=%h PC=%h adv=%b exp 3C3C/03/0", OPR, PC, advance); end
    tick();
    run = 1'b1;
    @(negedge clock);
    checks++; if (advance !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL rl_resume: got adv=%b req=%b exp 1/0", advance, mem_req); end
    tick();
    state = 6'd0;
    tick();
  endtask

  task automatic test_pc_wrap();
    int n = 0;
    while (PC !== 8'hFF && n < 300) begin
      do_fetch(6'd1, 16'(n));
      n++;
    end
    checks++; if (PC !== 8'hFF) begin errors++; $display("FAIL wrap_reach: got PC=%h exp FF", PC); end
    state = 6'd1; run = 1'b1;
    tick();
    mem_rvalid = 1'b1; mem_rdata = 16'h1234;
    @(negedge clock);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 8'hFF) begin errors++; $display("FAIL wrap_addr: got req=%b addr=%h exp 1/FF", mem_req, mem_addr); end
    tick();
    mem_rvalid = 1'b0;
    @(negedge clock);
    checks++; if (PC !== 8'h00 || IR !== 16'h1234) begin errors++; $display("FAIL wrap_pc: got PC=%h IR=%h exp 00/1234", PC, IR); end
    tick();
    state = 6'd0;
    tick();
  endtask

  task automatic test_reset_mid_request();
    do_fetch(6'd5, 16'h5A5A);
    state = 6'd1; run = 1'b1;
    tick();
    #2;
    reset = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0 || mem_addr !== 8'h00 || PC !== 8'h00) begin errors++; $display("FAIL rm_async: got req=%b addr=%h PC=%h exp 0/00/00", mem_req, mem_addr, PC); end
    checks++; if (IR !== 16'h0000 || OPR !== 16'h0000 || fetch_err !== 1'b0) begin errors++; $display("FAIL rm_regs: got IR=%h OPR=%h err=%b exp 0000/0000/0", IR, OPR, fetch_err); end
    tick();
    @(negedge clock);
    reset = 1'b0; run = 1'b0;
    tick();
    mem_rvalid = 1'b1; mem_rdata = 16'hBEEF;
    @(negedge clock);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rm_noreq: got %b exp 0", mem_req); end
    tick();
    mem_rvalid = 1'b0;
    @(negedge clock);
    checks++; if (IR !== 16'h0000 || PC !== 8'h00) begin errors++; $display("FAIL rm_late_rvalid: got IR=%h PC=%h exp 0000/00", IR, PC); end
    tick();
  endtask

  task automatic test_timeout();
    int hi = 0;
    state = 6'd1; run = 1'b1; mem_rvalid = 1'b0;
    tick();
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (mem_req === 1'b1) hi++;
      tick();
    end
    @(negedge clock);
`ifdef FETCH_TIMEOUT_EN
    checks++; if (hi != 15) begin errors++; $display("FAIL to_req_cycles: got %0d exp 15", hi); end
    checks++; if (mem_req !== 1'b0 || fetch_err !== 1'b1 || advance !== 1'b0) begin errors++; $display("FAIL to_err: got req=%b err=%b adv=%b exp 0/1/0", mem_req, fetch_err, advance); end
`else
    checks++; if (hi != 100) begin errors++; $display("FAIL to_req_cycles: got %0d exp 100", hi); end
    checks++; if (mem_req !== 1'b1 || fetch_err !== 1'b0 || advance !== 1'b0) begin errors++; $display("FAIL to_wait: got req=%b err=%b adv=%b exp 1/0/0", mem_req, fetch_err, advance); end
`endif
    checks++; if (PC !== 8'h00 || IR !== 16'h0000) begin errors++; $display("FAIL to_regs: got PC=%h IR=%h exp 00/0000", PC, IR); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch_and_operand();
    test_non_service();
    test_run_low_mid_request();
    test_pc_wrap();
    test_reset_mid_request();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
